// File: rtl/cl_sde_res_pack_if.sv
// Result-in / AXI-Stream-out bundle of the SDE result packer.
// master = packer side (drives res_ready and ots_*), slave = neighbours (drive res_* and ots_ready).
interface cl_sde_res_pack_if #(
  parameter int unsigned SW = 160
);
  logic          res_valid;
  logic          res_ready;
  logic [SW-1:0] res_data;

  logic          ots_valid;
  logic [511:0]  ots_data;
  logic [63:0]   ots_keep;
  logic [63:0]   ots_user;
  logic          ots_last;
  logic          ots_ready;

  modport master (
    input  res_valid, res_data, ots_ready,
    output res_ready, ots_valid, ots_data, ots_keep, ots_user, ots_last
  );

  modport slave (
    output res_valid, res_data, ots_ready,
    input  res_ready, ots_valid, ots_data, ots_keep, ots_user, ots_last
  );
endinterface

// File: rtl/cl_sde_res_pack.sv
// Packs classifier results (NUM_CLASSES signed scores each) into 512-bit AXI-Stream beats.
// Build option CL_SDE_RES_ARGMAX_EN adds per-slot argmax tagging in ots_user.
module cl_sde_res_pack #(
  parameter int unsigned NUM_CLASSES  = 10,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned RES_PER_BEAT = 3,
  parameter int unsigned BATCH_LEN    = 8,
  parameter int unsigned FLUSH_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  cl_sde_res_pack_if.master bus
);
  localparam int unsigned SW         = NUM_CLASSES * SCORE_W;
  localparam int unsigned DATA_W     = 512;
  localparam int unsigned KEEP_W     = DATA_W / 8;
  localparam int unsigned USER_W     = 64;
  localparam int unsigned SLOT_BYTES = (SW + 7) / 8;
  localparam int unsigned TAG_W      = 7;
  localparam int unsigned CNT_W      = $clog2(RES_PER_BEAT + 1);
  localparam int unsigned BCNT_W     = $clog2(BATCH_LEN + 1);
  localparam int unsigned TMR_W      = $clog2(FLUSH_CYCLES + 1);

  if (RES_PER_BEAT * SW > DATA_W || FLUSH_CYCLES < 1 || BATCH_LEN < 1) begin : g_bad_cfg
    $error("cl_sde_res_pack: illegal parameter combination");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  res_ready_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  lastp_q, lastp_d;
  logic                  acc_c, close_c, load_c;

  logic [SW-1:0]         slot_q [RES_PER_BEAT];

  logic                  ots_valid_q, ots_last_q;
  logic [DATA_W-1:0]     ots_data_q, pk_data_c;
  logic [KEEP_W-1:0]     ots_keep_q, pk_keep_c;
  logic [USER_W-1:0]     ots_user_q, pk_user_c;

  // res_ready_q is only high in FILL, so it alone qualifies an accept
  assign acc_c = bus.res_valid & res_ready_q;

`ifdef CL_SDE_RES_ARGMAX_EN
  localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic signed [SCORE_W-1:0] best_c, score_c;
  logic [IDX_W-1:0]          best_idx_c;
  logic [TAG_W-1:0]          tag_q [RES_PER_BEAT];

  // Strict '>' keeps the lowest index on ties
  always_comb begin
    best_c     = $signed(bus.res_data[SCORE_W-1:0]);
    best_idx_c = '0;
    score_c    = '0;
    for (int k = 1; k < NUM_CLASSES; k++) begin
      score_c = $signed(bus.res_data[k*SCORE_W +: SCORE_W]);
      if (score_c > best_c) begin
        best_c     = score_c;
        best_idx_c = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_PER_BEAT; i++) tag_q[i] <= '0;
    end else if (acc_c) begin
      for (int i = 0; i < RES_PER_BEAT; i++)
        if (cnt_q == CNT_W'(i)) tag_q[i] <= TAG_W'(best_idx_c);
    end
  end
`endif

  // Assembly buffer slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_PER_BEAT; i++) slot_q[i] <= '0;
    end else if (acc_c) begin
      for (int i = 0; i < RES_PER_BEAT; i++)
        if (cnt_q == CNT_W'(i)) slot_q[i] <= bus.res_data;
    end
  end

  // Beat image of the filled slots; empty slots stay zero
  always_comb begin
    pk_data_c = '0;
    pk_keep_c = '0;
    pk_user_c = '0;
    for (int i = 0; i < RES_PER_BEAT; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        pk_data_c[i*SW +: SW]                 = slot_q[i];
        pk_keep_c[i*SLOT_BYTES +: SLOT_BYTES] = '1;
`ifdef CL_SDE_RES_ARGMAX_EN
        pk_user_c[i*8 +: 8]                   = {1'b1, tag_q[i]};
`else
        pk_user_c[i*8 +: 8]                   = {1'b1, TAG_W'(0)};
`endif
      end
    end
  end

  // Next-state: fill/close decisions in FILL, hand-off to O in HOLD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;
    lastp_d = lastp_q;
    close_c = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      FILL: begin
        if (acc_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          tmr_d = '0;
          if (bcnt_q == BCNT_W'(BATCH_LEN - 1)) begin
            bcnt_d  = '0;
            lastp_d = 1'b1;
            close_c = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
          if (cnt_q == CNT_W'(RES_PER_BEAT - 1)) close_c = 1'b1;
        end else if (cnt_q != '0) begin
          if (tmr_q == TMR_W'(FLUSH_CYCLES - 1)) begin
            bcnt_d  = '0;
            lastp_d = 1'b1;
            close_c = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        if (close_c) begin
          state_d = HOLD;
          tmr_d   = '0;
        end
      end
      HOLD: begin
        if (!ots_valid_q || bus.ots_ready) begin
          state_d = FILL;
          load_c  = 1'b1;
          cnt_d   = '0;
          lastp_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      res_ready_q <= 1'b0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      lastp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_ready_q <= (state_d == FILL);
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      tmr_q       <= tmr_d;
      lastp_q     <= lastp_d;
    end
  end

  // Output register O: loaded from A on hand-off, held until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ots_valid_q <= 1'b0;
      ots_last_q  <= 1'b0;
      ots_data_q  <= '0;
      ots_keep_q  <= '0;
      ots_user_q  <= '0;
    end else if (load_c) begin
      ots_valid_q <= 1'b1;
      ots_last_q  <= lastp_q;
      ots_data_q  <= pk_data_c;
      ots_keep_q  <= pk_keep_c;
      ots_user_q  <= pk_user_c;
    end else if (bus.ots_ready) begin
      ots_valid_q <= 1'b0;
      ots_last_q  <= 1'b0;
    end
  end

  assign bus.res_ready = res_ready_q;
  assign bus.ots_valid = ots_valid_q;
  assign bus.ots_last  = ots_last_q;
  assign bus.ots_data  = ots_data_q;
  assign bus.ots_keep  = ots_keep_q;
  assign bus.ots_user  = ots_user_q;

endmodule

// File: tb/tb_cl_sde_res_pack.sv
// Randomized bench for cl_sde_res_pack with a transaction-level packing model.
// Expected user tags follow CL_SDE_RES_ARGMAX_EN the same way as the design build.
module tb_cl_sde_res_pack;
  localparam int NCLS  = 10;
  localparam int RPB   = 3;
  localparam int BATCH = 8;
  localparam int FLUSH = 16;
`ifdef CL_SDE_RES_ARGMAX_EN
  localparam bit ARG_ON = 1'b1;
`else
  localparam bit ARG_ON = 1'b0;
`endif

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [63:0]  user;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy_q  = 1'b1;
  logic fix_rdy = 1'b1;
  logic rnd_rdy = 1'b0;

  int total = 0;
  int bad   = 0;
  int nbeat = 0;
  int nlast = 0;
  int mb    = 0;
  int idle  = 0;

  logic [159:0] pend [$];
  beat_t        exp_q [$];

  cl_sde_res_pack_if bus ();

  cl_sde_res_pack #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  assign bus.ots_ready = rdy_q;

  always @(posedge clk) begin
    #1;
    rdy_q = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Argmax from the definition: largest value, then the first class holding it
  function automatic int argmax_ref(input logic [159:0] r);
    int v [NCLS];
    int mx;
    for (int k = 0; k < NCLS; k++) v[k] = int'($signed(r[k*16 +: 16]));
    mx = v[0];
    for (int k = 1; k < NCLS; k++) if (v[k] > mx) mx = v[k];
    for (int k = 0; k < NCLS; k++) if (v[k] == mx) return k;
    return 0;
  endfunction

  function automatic beat_t mk_beat(input logic lst);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.user = '0;
    b.last = lst;
    for (int i = 0; i < pend.size(); i++) begin
      b.data[i*160 +: 160] = pend[i];
      b.keep[i*20 +: 20]   = 20'hFFFFF;
      b.user[i*8 +: 8]     = {1'b1, ARG_ON ? 7'(argmax_ref(pend[i])) : 7'd0};
    end
    return b;
  endfunction

  function automatic void close_beat(input logic lst);
    exp_q.push_back(mk_beat(lst));
    pend.delete();
    idle = 0;
    if (lst) mb = 0;
  endfunction

  // Monitor: handshakes that will complete at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      exp_q.delete();
      mb   = 0;
      idle = 0;
    end else begin
      if (bus.ots_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_valid", 512'(bus.ots_valid), 512'(0));
        end else begin
          chk("ots_data", bus.ots_data, exp_q[0].data);
          chk("ots_keep", 512'(bus.ots_keep), 512'(exp_q[0].keep));
          chk("ots_user", 512'(bus.ots_user), 512'(exp_q[0].user));
          chk("ots_last", 512'(bus.ots_last), 512'(exp_q[0].last));
          if (bus.ots_ready) begin
            void'(exp_q.pop_front());
            nbeat++;
            if (bus.ots_last) nlast++;
          end
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        pend.push_back(bus.res_data);
        idle = 0;
        mb++;
        if (mb == BATCH) close_beat(1'b1);
        else if (pend.size() == RPB) close_beat(1'b0);
      end else if (pend.size() > 0) begin
        idle++;
        if (idle == FLUSH) close_beat(1'b1);
      end
    end
  end

  function automatic logic [159:0] ramp_res();
    logic [159:0] d;
    int base;
    base = int'($urandom_range(0, 1000)) - 500;
    for (int k = 0; k < NCLS; k++) d[k*16 +: 16] = 16'(base + k);
    return d;
  endfunction

  function automatic logic [159:0] rand_res();
    logic [159:0] d;
    for (int k = 0; k < NCLS; k++) d[k*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  // All stimulus tasks start and end at posedge+1
  task automatic send(input logic [159:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = bus.res_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 512'(acc), 512'(1));
    bus.res_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend.size() > 0 || bus.ots_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 512'(exp_q.size() + pend.size()), 512'(0));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ots_valid && n < 100);
  endtask

  task automatic run_batch8(input string pfx);
    int b0, l0;
    b0 = nbeat;
    l0 = nlast;
    for (int i = 0; i < BATCH; i++) send(ramp_res());
    drain();
    chk({pfx, "_beats"}, 512'(nbeat - b0), 512'(3));
    chk({pfx, "_lasts"}, 512'(nlast - l0), 512'(1));
  endtask

  initial begin
    logic [159:0] v;
    logic [63:0]  k40;
    int           n;
    k40 = (64'd1 << 40) - 64'd1;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    rst = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_ready", 512'(bus.res_ready), 512'(0));
    chk("rst_ots_valid", 512'(bus.ots_valid), 512'(0));
    chk("rst_ots_last",  512'(bus.ots_last),  512'(0));
    chk("rst_ots_data",  bus.ots_data,        512'(0));
    chk("rst_ots_keep",  512'(bus.ots_keep),  512'(0));
    chk("rst_ots_user",  512'(bus.ots_user),  512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 512'(bus.res_ready), 512'(1));

    // Back-to-back batch of 8 ramps -> 3/3/2 slots, last on the third
    run_batch8("s1");

    // Tie to lowest index, all-equal negative scores, then close latency
    v = '0;
    v[0*16 +: 16] = 16'sd5;
    v[1*16 +: 16] = -16'sd3;
    v[2*16 +: 16] = 16'sd7;
    v[3*16 +: 16] = 16'sd7;
    send(v);
    for (int k = 0; k < NCLS; k++) v[k*16 +: 16] = 16'hFFFF;
    send(v);
    send(rand_res());
    wait_valid(n);
    chk("close_latency", 512'(n), 512'(2));
    chk("tie_user",  512'(bus.ots_user[7:0]),  512'(ARG_ON ? 8'h82 : 8'h80));
    chk("neg_user",  512'(bus.ots_user[15:8]), 512'(8'h80));
    @(posedge clk);
    #1;
    drain();

    // Idle flush of a 2-slot partial beat
    send(rand_res());
    send(rand_res());
    wait_valid(n);
    chk("flush_latency", 512'(n), 512'(FLUSH + 2));
    chk("flush_keep", 512'(bus.ots_keep), 512'(k40));
    chk("flush_last", 512'(bus.ots_last), 512'(1));
    chk("flush_user2", 512'(bus.ots_user[23:16]), 512'(0));
    @(posedge clk);
    #1;
    drain();
    run_batch8("s3");

    // Output back-pressure: second closed beat parks A in HOLD
    fix_rdy = 1'b0;
    idle_cyc(2);
    for (int i = 0; i < 6; i++) send(rand_res());
    fork
      send(rand_res());
      begin
        idle_cyc(4);
        chk("stall_ready", 512'(bus.res_ready), 512'(0));
        chk("stall_valid", 512'(bus.ots_valid), 512'(1));
        chk("stall_keep",  512'(bus.ots_keep),  512'((64'd1 << 60) - 64'd1));
        fix_rdy = 1'b1;
      end
    join
    send(rand_res());
    drain();

    // Reset with cnt=2 in A and a beat pending in O
    fix_rdy = 1'b0;
    idle_cyc(2);
    for (int i = 0; i < 5; i++) send(rand_res());
    idle_cyc(2);
    chk("pre_rst_valid", 512'(bus.ots_valid), 512'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 512'(bus.ots_valid), 512'(0));
    chk("mid_rst_ready", 512'(bus.res_ready), 512'(0));
    chk("mid_rst_keep",  512'(bus.ots_keep),  512'(0));
    fix_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst2", 512'(bus.res_ready), 512'(1));
    run_batch8("s5");

    // Random results, gaps around the flush boundary, random ots_ready
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int g;
      g = int'($urandom_range(0, 9));
      send(rand_res());
      if (g == 9)      idle_cyc(FLUSH + 3);
      else if (g == 8) idle_cyc(FLUSH);
      else if (g == 7) idle_cyc(FLUSH - 1);
      else if (g >= 4) idle_cyc(g - 3);
    end
    rnd_rdy = 1'b0;
    idle_cyc(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
